// File: rtl/keypad_uart_pkg.sv
// keypad_uart_pkg: shared constants, state enums and key-map helper for the keypad UART link.
// Used by both the transmitter and receiver sides of the link.
package keypad_uart_pkg;

    localparam int         KP_CLK_HZ          = 27_000_000;
    localparam int         KP_BAUD            = 9600;
    localparam int         KP_DELAY_FRAMES    = KP_CLK_HZ / KP_BAUD;
    localparam int         KP_HALF_DELAY_WAIT = KP_DELAY_FRAMES / 2;
    localparam logic [7:0] KP_HEADER          = 8'h32;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} rx_state_e;
    typedef enum logic {P_HDR, P_KEY} parse_state_e;

    // Returns {valid, code}: '0'..'9' -> 0..9, 'A'..'D' -> A..D, '*' -> F, '#' -> E.
    function automatic logic [4:0] ascii_to_code(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
               (c >= 8'h41 && c <= 8'h44) ? {1'b1, c[3:0] + 4'd9} :
               (c == 8'h2A)               ? 5'h1F :
               (c == 8'h23)               ? 5'h1E : 5'h00;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with two-flop input synchronizer.
// Ports: clk, rst (sync, active-high); uart_rx_i async serial line (idle high);
//        rx_byte_o last good byte; rx_byte_valid_o / frame_err_o one-cycle strobes;
//        busy_o high whenever the FSM is not idle.
module uart_rx_byte
    import keypad_uart_pkg::*;
#(
    parameter int DELAY_FRAMES    = KP_DELAY_FRAMES,
    parameter int HALF_DELAY_WAIT = KP_HALF_DELAY_WAIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_byte_valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    // Counter compares against N-1 so "counter+1 == N" costs no adder.
    localparam logic [11:0] FULL_LAST = 12'(DELAY_FRAMES - 1);
    localparam logic [11:0] HALF_LAST = 12'(HALF_DELAY_WAIT - 1);

    rx_state_e   state_q, state_d;
    logic [1:0]  sync_q;
    logic        rx_s;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d, byte_q, byte_d;
    logic        valid_q, valid_d, ferr_q, ferr_d;
    logic        half_hit, full_hit;

    assign rx_s     = sync_q[1];
    assign half_hit = cnt_q == HALF_LAST;
    assign full_hit = cnt_q == FULL_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], uart_rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (!rx_s) state_d = S_START;
            S_START:     if (half_hit) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (full_hit && bit_q == 3'd7) state_d = S_STOP;
            S_STOP:      if (full_hit) state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = (state_q inside {S_START, S_DATA, S_STOP} &&
                   !(state_q == S_START ? half_hit : full_hit)) ? cnt_q + 12'd1 : 12'd0;
        bit_d   = state_q != S_DATA ? 3'd0 : full_hit ? bit_q + 3'd1 : bit_q;
        shift_d = shift_q;
        if (state_q == S_DATA && full_hit) shift_d[bit_q] = rx_s;
        valid_d = state_q == S_STOP && full_hit && rx_s;
        ferr_d  = state_q == S_STOP && full_hit && !rx_s;
        byte_d  = valid_d ? shift_q : byte_q;
    end

    assign rx_byte_o       = byte_q;
    assign rx_byte_valid_o = valid_q;
    assign frame_err_o     = ferr_q;
    assign busy_o          = state_q != S_IDLE;

endmodule

// File: rtl/uart_keypad_rx.sv
// uart_keypad_rx: keypad UART receiver; parses {HEADER, key-char} packets into 4-bit key codes.
// Ports: clk, rst (sync, active-high); uart_rx serial line; rx_byte/rx_byte_valid raw bytes;
//        code/code_valid decoded key; frame_err, proto_err one-cycle error strobes; busy.
module uart_keypad_rx
    import keypad_uart_pkg::*;
#(
    parameter int         CLK_HZ          = 27_000_000,
    parameter int         BAUD            = 9600,
    parameter int         DELAY_FRAMES    = CLK_HZ / BAUD,
    parameter int         HALF_DELAY_WAIT = DELAY_FRAMES / 2,
    parameter logic [7:0] HEADER          = KP_HEADER,
    parameter int         TIMEOUT_BITS    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic [3:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       proto_err,
    output logic       busy
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_BITS * DELAY_FRAMES);

    parse_state_e p_q, p_d;
    logic [15:0]  tmo_q, tmo_d;
    logic [3:0]   code_q, code_d;
    logic         cv_q, cv_d, pe_q, pe_d;
    logic [4:0]   key;
    logic         tmo_hit;

    uart_rx_byte #(
        .DELAY_FRAMES   (DELAY_FRAMES),
        .HALF_DELAY_WAIT(HALF_DELAY_WAIT)
    ) u_byte (
        .clk            (clk),
        .rst            (rst),
        .uart_rx_i      (uart_rx),
        .rx_byte_o      (rx_byte),
        .rx_byte_valid_o(rx_byte_valid),
        .frame_err_o    (frame_err),
        .busy_o         (busy)
    );

    assign key = ascii_to_code(rx_byte);
    // The timeout only advances while the line is idle, so it fires between bytes only.
    assign tmo_hit = p_q == P_KEY && !busy && tmo_q >= TMO_LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q    <= P_HDR;
            tmo_q  <= '0;
            code_q <= '0;
            cv_q   <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            p_q    <= p_d;
            tmo_q  <= tmo_d;
            code_q <= code_d;
            cv_q   <= cv_d;
            pe_q   <= pe_d;
        end
    end

    always_comb begin
        p_d = p_q;
        if (rx_byte_valid) p_d = (p_q == P_HDR && rx_byte == HEADER) ? P_KEY : P_HDR;
        else if (frame_err || tmo_hit) p_d = P_HDR;
    end

    always_comb begin
        tmo_d  = p_q != P_KEY ? 16'd0 : (busy || &tmo_q) ? tmo_q : tmo_q + 16'd1;
        cv_d   = rx_byte_valid && p_q == P_KEY && key[4];
        code_d = cv_d ? key[3:0] : code_q;
        pe_d   = rx_byte_valid ? !(p_q == P_HDR ? rx_byte == HEADER : key[4]) : tmo_hit;
    end

    assign code       = code_q;
    assign code_valid = cv_q;
    assign proto_err  = pe_q;

endmodule

// File: tb/tb_uart_keypad_rx.sv
// tb_uart_keypad_rx: self-checking bench for uart_keypad_rx at a shortened bit period.
module tb_uart_keypad_rx;

    localparam int DF      = 16;
    localparam int TO_BITS = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic [3:0] code;
    logic       code_valid, frame_err, proto_err, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_bytes[$];
    logic [3:0] got_codes[$];
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         seq_err = 0;
    logic       prev_rbv = 1'b0;
    int         b0, c0, f0, p0;

    string kmap = "0123456789ABCD";
    string pool = "0123456789ABCD*#";

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] key;
        int         exp_code;
        int         exp_pe;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    uart_keypad_rx #(
        .CLK_HZ      (DF * 9600),
        .BAUD        (9600),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .code         (code),
        .code_valid   (code_valid),
        .frame_err    (frame_err),
        .proto_err    (proto_err),
        .busy         (busy)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_byte_valid) got_bytes.push_back(rx_byte);
            if (code_valid) begin
                got_codes.push_back(code);
                if (!prev_rbv) seq_err++;
            end
            if (frame_err) fe_cnt++;
            if (proto_err) pe_cnt++;
        end
        prev_rbv = rx_byte_valid;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            wait_clks(DF);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic idle_bits(input int n);
        uart_rx = 1'b1;
        wait_clks(n * DF);
    endtask

    task automatic mark;
        b0 = got_bytes.size();
        c0 = got_codes.size();
        f0 = fe_cnt;
        p0 = pe_cnt;
    endtask

    function automatic int model_map(input logic [7:0] b);
        for (int i = 0; i < kmap.len(); i++)
            if (8'(kmap[i]) == b) return i;
        if (b == 8'h2A) return 15;
        if (b == 8'h23) return 14;
        return -1;
    endfunction

    initial begin
        int prev_code;
        int pk, exp_pe;
        logic [7:0] exp_b[$];
        int exp_c[$];
        logic [9:0] f;

        vecs[0] = '{8'h32, 8'h35, 5, 0};
        vecs[1] = '{8'h32, 8'h2A, 15, 0};
        vecs[2] = '{8'h32, 8'h23, 14, 0};
        vecs[3] = '{8'h32, 8'h30, 0, 0};
        vecs[4] = '{8'h32, 8'h39, 9, 0};
        vecs[5] = '{8'h32, 8'h41, 10, 0};
        vecs[6] = '{8'h32, 8'h44, 13, 0};
        vecs[7] = '{8'h32, 8'h32, 2, 0};
        vecs[8] = '{8'h32, 8'h45, -1, 1};
        vecs[9] = '{8'h32, 8'h61, -1, 1};

        wait_clks(3);
        check("reset_rx_byte", int'(rx_byte), 0);
        check("reset_code", int'(code), 0);
        check("reset_rx_byte_valid", int'(rx_byte_valid), 0);
        check("reset_code_valid", int'(code_valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_proto_err", int'(proto_err), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        wait_clks(4);

        prev_code = 0;
        for (int v = 0; v < 10; v++) begin
            mark();
            send_byte(vecs[v].hdr);
            send_byte(vecs[v].key);
            idle_bits(2);
            check($sformatf("vec%0d_nbytes", v), got_bytes.size() - b0, 2);
            if (got_bytes.size() - b0 == 2) begin
                check($sformatf("vec%0d_byte0", v), int'(got_bytes[b0]), int'(vecs[v].hdr));
                check($sformatf("vec%0d_byte1", v), int'(got_bytes[b0 + 1]), int'(vecs[v].key));
            end
            check($sformatf("vec%0d_ncodes", v), got_codes.size() - c0, vecs[v].exp_code >= 0 ? 1 : 0);
            if (vecs[v].exp_code >= 0) prev_code = vecs[v].exp_code;
            check($sformatf("vec%0d_code", v), int'(code), prev_code);
            check($sformatf("vec%0d_proto_err", v), pe_cnt - p0, vecs[v].exp_pe);
            check($sformatf("vec%0d_frame_err", v), fe_cnt - f0, 0);
        end

        // short low glitch on an idle line
        mark();
        uart_rx = 1'b0;
        wait_clks(4);
        check("glitch_busy_high", int'(busy), 1);
        uart_rx = 1'b1;
        wait_clks(DF / 2 + 4);
        check("glitch_busy_low", int'(busy), 0);
        check("glitch_no_bytes", got_bytes.size() - b0, 0);
        check("glitch_no_ferr", fe_cnt - f0, 0);
        check("glitch_no_perr", pe_cnt - p0, 0);

        // bad stop bit followed by a held break
        mark();
        send_byte(8'h32);
        send_frame(8'h55, 1'b0);
        wait_clks(600);
        check("break_busy_held", int'(busy), 1);
        check("break_ferr_once", fe_cnt - f0, 1);
        check("break_no_perr", pe_cnt - p0, 0);
        check("break_nbytes", got_bytes.size() - b0, 1);
        idle_bits(2);
        check("break_busy_released", int'(busy), 0);
        mark();
        send_byte(8'h32);
        send_byte(8'h37);
        idle_bits(2);
        check("after_break_ncodes", got_codes.size() - c0, 1);
        check("after_break_code", int'(code), 7);
        check("after_break_perr", pe_cnt - p0, 0);

        // bad header
        mark();
        send_byte(8'h58);
        idle_bits(2);
        check("bad_hdr_perr", pe_cnt - p0, 1);
        check("bad_hdr_ncodes", got_codes.size() - c0, 0);

        // timeout after header, then parser must be back in header state
        mark();
        send_byte(8'h32);
        idle_bits(TO_BITS + 2);
        check("timeout_perr", pe_cnt - p0, 1);
        mark();
        send_byte(8'h35);
        idle_bits(2);
        check("timeout_back_to_hdr_perr", pe_cnt - p0, 1);
        check("timeout_back_to_hdr_ncodes", got_codes.size() - c0, 0);

        // gap just inside the timeout
        mark();
        send_byte(8'h32);
        idle_bits(TO_BITS - 3);
        send_byte(8'h36);
        idle_bits(2);
        check("near_timeout_perr", pe_cnt - p0, 0);
        check("near_timeout_code", int'(code), 6);

        // reset in the middle of data bit 4 of the key byte
        mark();
        send_byte(8'h32);
        f = {1'b1, 8'h30, 1'b0};
        for (int i = 0; i < 5; i++) begin
            uart_rx = f[i];
            wait_clks(DF);
        end
        uart_rx = f[5];
        wait_clks(DF / 2);
        rst = 1'b1;
        wait_clks(1);
        check("midrst_rx_byte", int'(rx_byte), 0);
        check("midrst_code", int'(code), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_strobes", int'({rx_byte_valid, code_valid, frame_err, proto_err}), 0);
        rst = 1'b0;
        uart_rx = 1'b1;
        idle_bits(2);
        check("midrst_no_partial_byte", got_bytes.size() - b0, 1);
        mark();
        send_byte(8'h32);
        send_byte(8'h30);
        idle_bits(2);
        check("midrst_after_ncodes", got_codes.size() - c0, 1);
        if (got_codes.size() - c0 == 1) check("midrst_after_code", int'(got_codes[c0]), 0);

        // random byte stream against a packet-level model
        mark();
        pk = 0;
        exp_pe = 0;
        for (int n = 0; n < 40; n++) begin
            int r, gap, m;
            logic [7:0] b;
            r = $urandom_range(0, 3);
            b = (r == 1) ? 8'(pool[$urandom_range(0, 15)]) : (r == 2) ? 8'($urandom) : 8'h32;
            exp_b.push_back(b);
            if (pk != 0) begin
                m = model_map(b);
                if (m >= 0) exp_c.push_back(m);
                else exp_pe++;
                pk = 0;
            end else if (b == 8'h32) pk = 1;
            else exp_pe++;
            gap = ($urandom_range(0, 4) == 0 || n == 39) ? TO_BITS + 10 : $urandom_range(1, 8);
            send_byte(b);
            idle_bits(gap);
            if (pk != 0 && gap > TO_BITS) begin
                exp_pe++;
                pk = 0;
            end
        end
        check("rand_nbytes", got_bytes.size() - b0, exp_b.size());
        if (got_bytes.size() - b0 == exp_b.size())
            foreach (exp_b[i]) check($sformatf("rand_byte%0d", i), int'(got_bytes[b0 + i]), int'(exp_b[i]));
        check("rand_ncodes", got_codes.size() - c0, exp_c.size());
        if (got_codes.size() - c0 == exp_c.size())
            foreach (exp_c[i]) check($sformatf("rand_code%0d", i), int'(got_codes[c0 + i]), exp_c[i]);
        check("rand_perr", pe_cnt - p0, exp_pe);
        check("rand_ferr", fe_cnt - f0, 0);

        check("code_valid_follows_byte", seq_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_keypad_rx.md
# uart_keypad_rx

UART receiver and packet decoder at the far end of the keypad UART link. It deserialises 8N1 frames at 9600 baud from a 27 MHz clock and parses the two-byte key packet: header `"2"` (8'h32), then one ASCII key character. It returns the same 4-bit key code the keypad encoder produces, plus raw-byte and error strobes for debug LEDs or host logic.

## Interface
Parameters:
- CLK_HZ, 27_000_000, system clock frequency.
- BAUD, 9600, line rate.
- DELAY_FRAMES, CLK_HZ/BAUD (=2812, integer division), clocks per bit.
- HALF_DELAY_WAIT, DELAY_FRAMES/2 (=1406), clocks from start-edge detect to mid-start-bit sample.
- HEADER, 8'h32, packet header byte.
- TIMEOUT_BITS, 20, maximum bit times allowed between header stop bit and key start bit.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- uart_rx  in  1  asynchronous serial line, idle high.
- rx_byte  out  8  last correctly framed byte.
- rx_byte_valid  out  1  one-cycle pulse; rx_byte updated.
- code  out  4  decoded key code; holds until next valid key.
- code_valid  out  1  one-cycle pulse; new code.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- proto_err  out  1  one-cycle pulse; bad header, bad key char or timeout.
- busy  out  1  high while the byte FSM is not IDLE.

## Operation
- Input sync: two flops, both reset to 1; all logic uses the second flop (rx_s).
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START, counter=0.
  - START: at counter+1==HALF_DELAY_WAIT: rx_s==0 -> DATA, counter=0, bit=0; rx_s==1 -> IDLE (glitch rejected, no strobe).
  - DATA: at counter+1==DELAY_FRAMES, shift[bit]=rx_s (LSB first). Bit 7 -> STOP, else bit+1. counter=0.
  - STOP: at counter+1==DELAY_FRAMES: rx_s==1 -> rx_byte=shift, rx_byte_valid, IDLE; rx_s==0 -> frame_err, WAIT_HIGH.
  - WAIT_HIGH: stays until rx_s==1, then IDLE. This prevents re-triggering on a break condition.
- Parser states: P_HDR, P_KEY.
  - P_HDR: byte==HEADER -> P_KEY and clear the timeout counter. Any other byte -> proto_err, stay in P_HDR.
  - P_KEY, key map: '0'..'9' -> 0..9; 'A'..'D' -> A..D; '*' -> F; '#' -> E.
    - Mapped byte -> code, code_valid, P_HDR.
    - Any other byte -> proto_err, P_HDR.
    - Byte '2' in P_KEY is key 2, not a new header.
  - P_KEY, other exits:
    - frame_err -> P_HDR, no proto_err.
    - Timeout counter reaches TIMEOUT_BITS*DELAY_FRAMES while the byte FSM is IDLE -> proto_err, P_HDR.
- Counter widths: the bit counter is 12 bits. The timeout counter is 16 bits and saturates.

## Timing
- Reset values:
  - rx_byte=0, code=0; all strobes=0; busy=0.
  - FSMs in IDLE/P_HDR; sync flops=1.
- Cycle numbering: cycle 0 is the first clk where rx_s==0 in IDLE. rx_s lags the pin by 2 cycles.
- Start bit sampled at cycle HALF_DELAY_WAIT-1. Data bit n sampled at HALF_DELAY_WAIT-1+(n+1)·DELAY_FRAMES. Stop bit sampled at HALF_DELAY_WAIT-1+9·DELAY_FRAMES.
- rx_byte_valid and frame_err assert the cycle after the stop sample. code_valid and proto_err assert one cycle after rx_byte_valid.
- Simultaneous events: a byte's parser action and the timeout cannot coincide, because the timeout is only counted in IDLE. A new start edge in the cycle the STOP state exits is taken on the next cycle.
- rst mid-frame: everything returns to reset values on the next edge. No strobe is emitted for the partial byte.

## Structure
- Package keypad_uart_pkg:
  - DELAY_FRAMES and HALF_DELAY_WAIT defaults; HEADER.
  - Byte-FSM and parser state enums.
  - ascii_to_code function returning {valid, code[3:0]}.
  - The same package is reused by the transmitter side.
- Sub-module uart_rx_byte holds the synchronizer and byte FSM (uart_rx in; rx_byte, rx_byte_valid, frame_err, busy out). The top holds the parser and timeout.

## Test plan
- Send "2","5" at 2812 clk/bit -> rx_byte_valid twice (8'h32, 8'h35); exactly one code_valid with code=4'h5; no errors.
- Send "2","*", then "2","#" -> code_valid with code=4'hF, then with code=4'hE.
- Low glitch of 500 cycles on an idle line -> no strobes; busy returns low by cycle 1406.
- Send "2", then a frame whose stop bit is 0 -> frame_err one pulse. Hold the line low 10 000 cycles: FSM stays in WAIT_HIGH. Then "2","7" -> code=7.
- Send "X" -> proto_err. Send "2", idle 20·2812 cycles -> proto_err; parser back in P_HDR.
- Assert rst during data bit 4 of the key byte -> all outputs 0 next cycle. Then "2","0" -> code=0, code_valid.
